// File: rtl/sub32_pkg.sv
// Shared types and lookahead helpers for the two-stage 32-bit subtractor.
// With SUB32_OVF_EN defined, the S1 payload also carries the operand sign bits.
package sub32_pkg;

  localparam int WIDTH = 32;
  localparam int HALF  = 16;

  typedef struct packed {
    logic [HALF-1:0] d_lo;
    logic            c16;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;
`ifdef SUB32_OVF_EN
    logic            a_sign;
    logic            b_sign;
`endif
  } s1_payload_t;

  // Group generate of a 4-bit block: a carry leaves the block regardless of carry-in.
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carries into positions 0..3 of a 4-wide block, all two-level from cin.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/sub_32bit_pipe_if.sv
// Streaming operand/result bundle for sub_32bit_pipe; slave is the subtractor side.
// The ovf signal exists only when SUB32_OVF_EN is defined.
interface sub_32bit_pipe_if;
  import sub32_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             zero;
`ifdef SUB32_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef SUB32_OVF_EN
    input  ovf,
`endif
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, D, bout, zero
  );

  modport slave (
`ifdef SUB32_OVF_EN
    output ovf,
`endif
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, D, bout, zero
  );

endinterface

// File: rtl/sub_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit generate/propagate groups joined by a
// second lookahead level. The parent feeds b inverted to subtract.
module sub_cla16
  import sub32_pkg::*;
(
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic            cin,
  output logic [HALF-1:0] s,
  output logic            cout
);

  logic [HALF-1:0] g;
  logic [HALF-1:0] p;
  logic [HALF-1:0] c;
  logic [3:0]      gg;
  logic [3:0]      gp;
  logic [3:0]      gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k]        = grp_gen(g[4*k +: 4], p[4*k +: 4]);
    assign gp[k]        = &p[4*k +: 4];
    assign c[4*k +: 4]  = cla4_carries(g[4*k +: 4], p[4*k +: 4], gc[k]);
  end

  // Same lookahead equations one level up, over the group G/P terms.
  assign gc   = cla4_carries(gg, gp, cin);
  assign cout = grp_gen(gg, gp) | (&gp & cin);
  assign s    = p ^ c;

endmodule

// File: rtl/sub_32bit_pipe.sv
// Two-stage pipelined 32-bit subtractor (D = A + ~B + 1) with valid/ready on both sides.
// Optional signed-overflow output under SUB32_OVF_EN.
module sub_32bit_pipe
  import sub32_pkg::HALF, sub32_pkg::s1_payload_t;
#(
  parameter int WIDTH = sub32_pkg::WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  sub_32bit_pipe_if.slave bus
);

  s1_payload_t      s1_q;
  logic             v1_q;
  logic             v2_q;
  logic             s2_adv;
  logic             in_fire;
  logic [HALF-1:0]  b_lo_n;
  logic [HALF-1:0]  b_hi_n;
  logic [HALF-1:0]  lo_sum;
  logic [HALF-1:0]  hi_sum;
  logic             lo_cout;
  logic             hi_cout;
  logic [WIDTH-1:0] d_next;

  assign s2_adv        = v1_q && (!v2_q || bus.out_ready);
  assign bus.in_ready  = !v1_q || s2_adv;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = v2_q;

  assign b_lo_n = ~bus.B[HALF-1:0];
  assign b_hi_n = ~s1_q.b_hi;

  sub_cla16 u_lo (
    .a    (bus.A[HALF-1:0]),
    .b    (b_lo_n),
    .cin  (1'b1),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  sub_cla16 u_hi (
    .a    (s1_q.a_hi),
    .b    (b_hi_n),
    .cin  (s1_q.c16),
    .s    (hi_sum),
    .cout (hi_cout)
  );

  assign d_next = {hi_sum, s1_q.d_lo};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let v2 see the already-updated v1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (in_fire)     v1_q <= 1'b1;
      else if (s2_adv) v1_q <= 1'b0;

      if (s2_adv)             v2_q <= 1'b1;
      else if (bus.out_ready) v2_q <= 1'b0;
    end
  end

  // NOTE: the S1 payload has no reset; v1 alone says whether it is meaningful, and
  // leaving the reset off keeps these flops plain enables.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_q.d_lo   <= lo_sum;
      s1_q.c16    <= lo_cout;
      s1_q.a_hi   <= bus.A[WIDTH-1:HALF];
      s1_q.b_hi   <= bus.B[WIDTH-1:HALF];
`ifdef SUB32_OVF_EN
      s1_q.a_sign <= bus.A[WIDTH-1];
      s1_q.b_sign <= bus.B[WIDTH-1];
`endif
    end
  end

  // Result registers load only when S1 advances, so they hold through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.D    <= '0;
      bus.bout <= 1'b0;
      bus.zero <= 1'b0;
`ifdef SUB32_OVF_EN
      bus.ovf  <= 1'b0;
`endif
    end else if (s2_adv) begin
      bus.D    <= d_next;
      bus.bout <= ~hi_cout;
      bus.zero <= (d_next == '0);
`ifdef SUB32_OVF_EN
      bus.ovf  <= (s1_q.a_sign != s1_q.b_sign) && (d_next[WIDTH-1] != s1_q.a_sign);
`endif
    end
  end

endmodule
